// File: rtl/i2s_slave_tx.sv
// i2s_slave_tx: I2S target transmitter, follows external sck/ws and shifts L/R words out on sd_o, MSB first, Philips timing
// Ports: wb_clk_i/wb_rst_i system clock and sync active-high reset; sck_i/ws_i bus clock and word select (async);
//        sd_o serial data; l_data_i/r_data_i/frame_valid_i/frame_ready_o frame input handshake;
//        underrun_o pulse when a left word starts with no frame held; active_o high in LEFT/RIGHT.
// Option: define I2S_TX_UNDERRUN_REPEAT_EN to repeat the last frame on underrun instead of sending zeros.
module i2s_slave_tx #(
   parameter int DATA_W      = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              sck_i,
   input  logic              ws_i,
   output logic              sd_o,
   input  logic [DATA_W-1:0] l_data_i,
   input  logic [DATA_W-1:0] r_data_i,
   input  logic              frame_valid_i,
   output logic              frame_ready_o,
   output logic              underrun_o,
   output logic              active_o
);
   localparam logic [1:0] S_IDLE = 2'd0, S_LEFT = 2'd1, S_RIGHT = 2'd2;
   localparam int CNT_W = $clog2(DATA_W + 1);
   logic [SYNC_STAGES-1:0] r_sck_sync, r_ws_sync;
   logic r_sck_prev, r_ws_cur, r_ws_last, r_hold_full, r_underrun;
   logic [1:0] r_state;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [DATA_W-1:0] r_shift, r_act_r, r_hold_l, r_hold_r;
   logic w_sck, w_rise, w_fall, w_start, w_xfer, w_load_r, w_acc;
   logic [DATA_W-1:0] w_new_l, w_new_r;
   assign w_sck    = r_sck_sync[SYNC_STAGES-1];
   assign w_rise   = ~r_sck_prev & w_sck;
   assign w_fall   = r_sck_prev & ~w_sck;
   // ws_cur/ws_last only move on rising edges, so the change flag covers exactly the next falling edge
   assign w_start  = w_fall & (r_ws_cur != r_ws_last);
   assign w_xfer   = w_start & ~r_ws_cur;
   assign w_load_r = w_start & r_ws_cur & (r_state != S_IDLE);
   assign w_acc    = frame_valid_i & ~r_hold_full;
   assign sd_o          = r_shift[DATA_W-1];
   assign frame_ready_o = ~r_hold_full;
   assign underrun_o    = r_underrun;
   assign active_o      = r_state != S_IDLE;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
   logic [DATA_W-1:0] r_act_l;
   assign w_new_l = r_hold_full ? r_hold_l : r_act_l;
   assign w_new_r = r_hold_full ? r_hold_r : r_act_r;
   always_ff @(posedge wb_clk_i)
      if (wb_rst_i) r_act_l <= '0;
      else if (w_xfer) r_act_l <= w_new_l;
`else
   assign w_new_l = r_hold_full ? r_hold_l : '0;
   assign w_new_r = r_hold_full ? r_hold_r : '0;
`endif
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_sck_sync  <= '0;
         r_ws_sync   <= '0;
         r_sck_prev  <= 1'b0;
         r_ws_cur    <= 1'b0;
         r_ws_last   <= 1'b0;
         r_hold_full <= 1'b0;
         r_underrun  <= 1'b0;
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_act_r     <= '0;
         r_hold_l    <= '0;
         r_hold_r    <= '0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
         r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], ws_i};
         r_sck_prev  <= w_sck;
         if (w_rise) begin
            r_ws_cur  <= r_ws_sync[SYNC_STAGES-1];
            r_ws_last <= r_ws_cur;
         end
         r_underrun  <= w_xfer & ~r_hold_full;
         r_hold_full <= w_acc | (r_hold_full & ~w_xfer);
         if (w_acc) begin
            r_hold_l <= l_data_i;
            r_hold_r <= r_data_i;
         end
         if (w_xfer) begin
            r_act_r   <= w_new_r;
            r_shift   <= w_new_l;
            r_bit_cnt <= '0;
            r_state   <= S_LEFT;
         end else if (w_load_r) begin
            r_shift   <= r_act_r;
            r_bit_cnt <= '0;
            r_state   <= S_RIGHT;
         end else if (w_fall && r_state != S_IDLE) begin
            // past the last data bit the slot is padded with zeros
            r_shift   <= (r_bit_cnt < CNT_W'(DATA_W - 1)) ? {r_shift[DATA_W-2:0], 1'b0} : '0;
            r_bit_cnt <= (r_bit_cnt == CNT_W'(DATA_W)) ? r_bit_cnt : r_bit_cnt + 1'b1;
         end
      end
   end
endmodule
